// File: rtl/i2s_tx_pkg.sv
// Shared types and constants for the I2S transmitter: FSM state, slot/word sizes,
// midscale offset and the slot-bit selection helper.
package i2s_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int unsigned SLOT_BITS = 32;
    localparam int unsigned DATA_BITS = 24;
    localparam logic [19:0] MIDSCALE  = 20'h80000;

    // Slot position 0 is a one-bit I2S delay, 1..24 carry the word MSB first, the rest pad with 0.
    function automatic logic slot_bit(input logic [DATA_BITS-1:0] word, input logic [4:0] idx);
        logic [4:0] pos;
        if (idx == 5'd0 || idx > 5'(DATA_BITS)) begin
            return 1'b0;
        end
        pos = 5'(DATA_BITS) - idx;
        return word[pos];
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV while run is high and flags the
// clk cycle whose edge produces a bclk falling edge.
module i2s_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic bit_adv
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div;
    logic       wrap;

    assign wrap    = run && (div == DIV_LAST);
    assign bit_adv = wrap && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (!run) begin
            div  <= '0;
            bclk <= 1'b0;
        end else if (wrap) begin
            div  <= '0;
            bclk <= ~bclk;
        end else begin
            div <= div + 8'd1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter for a 20-bit unsigned mixed voice sum, 24-bit mono word in both slots.
// Optional mute input compiled in with `define I2S_TX_MUTE_EN.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [19:0] mixed_signal,
`ifdef I2S_TX_MUTE_EN
    input  logic        mute,
`endif
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        sample_strobe,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(2 * SLOT_BITS);

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       next_cnt;
    logic [DATA_BITS-1:0]   word;
    logic [DATA_BITS-1:0]   fresh;
    logic [19:0]            pcm;
    logic                   run;
    logic                   bit_adv;
    logic                   frame_end;

    always_comb begin
        pcm   = mixed_signal - MIDSCALE;
        fresh = {pcm, 4'b0000};
`ifdef I2S_TX_MUTE_EN
        if (mute) begin
            fresh = '0;
        end
`endif
    end

    assign run       = (state != IDLE);
    assign busy      = run;
    assign lrclk     = bit_cnt[CNT_W-1];
    assign next_cnt  = bit_cnt + CNT_W'(1);
    assign frame_end = bit_adv && (bit_cnt == '1);

    i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .bclk    (bclk),
        .bit_adv (bit_adv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            word          <= '0;
            sdata         <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state         <= RUN;
                        word          <= fresh;
                        sample_strobe <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    // A draining frame ends at the 63->0 wrap; otherwise the wrap recaptures.
                    if (frame_end && state == DRAIN && !enable) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        sdata   <= 1'b0;
                    end else begin
                        state <= enable ? RUN : DRAIN;
                        if (bit_adv) begin
                            bit_cnt <= next_cnt;
                            sdata   <= slot_bit(word, next_cnt[4:0]);
                        end
                        if (frame_end) begin
                            word          <= fresh;
                            sample_strobe <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per bclk half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  start/continue transmission; sampled each clk.
REQ-005 mixed_signal  input  20  unsigned sum of 16 voices (0..0xFFFF0), midscale 0x80000.
REQ-006 bclk  output  1  I2S bit clock.
REQ-007 lrclk  output  1  word select; 0 = left slot, 1 = right slot.
REQ-008 sdata  output  1  serial data, MSB first.
REQ-009 sample_strobe  output  1  one-clk pulse when mixed_signal is captured.
REQ-010 busy  output  1  high while not in IDLE.

Function
REQ-011 FSM states IDLE, RUN, DRAIN shall exist; the state register shall hold exactly one of these states.
REQ-012 IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE at end of bit 63; DRAIN->RUN if enable=1 again before end of frame.
REQ-013 In IDLE, bclk, lrclk, sdata shall be 0, and the divider and bit counter shall hold 0.
REQ-014 In RUN/DRAIN, a divider shall count 0..CLK_DIV-1, and bclk shall toggle when the divider wraps.
REQ-015 A 6-bit bit counter shall advance on each bclk falling edge, wrap 63->0, and never skip or repeat.
REQ-016 lrclk shall equal bit-counter bit 5, so bits 0-31 form the left slot and bits 32-63 form the right slot.
REQ-017 Sample conversion: pcm = mixed_signal - 0x80000, as 20-bit two's complement; the 24-bit word shall be {pcm, 4'b0000}.
REQ-018 The sample shall be captured, and sample_strobe pulsed, in the clk cycle the bit counter enters 0, including the first frame after IDLE->RUN.
REQ-019 Both slots of a frame shall carry the same captured word (mono duplicated).
REQ-020 Slot bit index s (0..31): s=0 shall be 0; s=1..24 shall be word[23]..word[0]; s=25..31 shall be 0.
REQ-021 sdata, lrclk, and the bit counter shall change only on bclk falling edges, so they are stable at each bclk rising edge.
REQ-022 mixed_signal changes between captures shall not affect the frame in progress.
REQ-023 On enable deassertion mid-frame, the current frame shall complete through bit 63; no capture shall occur in DRAIN.
REQ-024 The first bclk rising edge after IDLE->RUN shall occur CLK_DIV cycles after entry.

Reset
REQ-025 While rst_n=0, all outputs shall be 0, the state shall be IDLE, the counters shall be 0, and the holding register shall be 0x000000.
REQ-026 Reset assertion mid-frame shall abort immediately, with no completion of the frame.
REQ-027 After reset release, the block shall leave IDLE only on enable=1.

Configuration
REQ-028 Macro I2S_TX_MUTE_EN shall compile in a 1-bit input mute.
REQ-029 With I2S_TX_MUTE_EN defined and mute=1 at capture, the captured word shall be 0x000000; mute shall take effect only at frame boundaries.
REQ-030 Without I2S_TX_MUTE_EN, the mute port shall not exist and the behaviour shall be as in REQ-017.

Structure
REQ-031 A shared package shall hold the FSM state typedef, SLOT_BITS=32, DATA_BITS=24, and MIDSCALE=20'h80000.
REQ-032 Sub-module i2s_clk_gen shall generate bclk and bit-counter enables; the shift/capture logic and FSM shall stay in i2s_tx.

Verification
REQ-033 CLK_DIV=2, enable=1, mixed_signal=0x80000 -> both slots all zeros; sample_strobe once per 256 clk cycles.
REQ-034 mixed_signal=0xFFFF0 -> slot bits 1-24 = 0x7FFF00 (0111 1111 1111 1111 0000 0000), bits 0 and 25-31 = 0.
REQ-035 mixed_signal=0x00000 -> word 0x800000; left and right slots identical; lrclk period = 64 bclk.
REQ-036 enable dropped at bit 10 -> frame completes to bit 63; no second strobe; IDLE with all outputs 0; busy falls.
REQ-037 rst_n pulsed low at bit 40 -> outputs 0 asynchronously; after release with enable=1 -> fresh frame starting at bit 0 with a new capture.
REQ-038 I2S_TX_MUTE_EN defined, mute=1 asserted mid-frame with mixed_signal=0xFFFF0 -> current frame unchanged; next frame all zeros.
